// File: rtl/pc_fetch_rv32i_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and the
// instruction memory (slave).
interface pc_fetch_rv32i_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_rv32i.sv
// Program-counter and instruction-fetch stage for the single-issue RV32I core.
// Holds the PC, offers PC+4 to the brancher, fetches over a req/ack bus and
// holds the fetched word for decode until the core advances.
// Optional fetch timeout: define PC_FETCH_TIMEOUT_EN to build the wait counter
// and the timeout_err path; otherwise FETCH waits indefinitely.
module pc_fetch_rv32i #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned WAIT_MAX     = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              PCin,
  input  logic                     advance,
  input  logic                     stall,
  pc_fetch_rv32i_if.master         bus,
  output logic [31:0]              PC,
  output logic [31:0]              PCnew,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic                     misalign_err,
  output logic                     timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_misalign;
  logic        w_accept;

  // An advance counts only in HOLD and only when no hazard stall is present.
  assign w_accept = (r_state == S_HOLD) && advance && !stall;

`ifdef PC_FETCH_TIMEOUT_EN
  localparam logic [7:0] LP_CNT_LAST = 8'(WAIT_MAX - 1);

  logic [7:0] r_cnt;
  logic       r_timeout;

  // Counts consecutive un-acked FETCH cycles; ack wins over timeout in the
  // last allowed cycle because the ack branch is evaluated first.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_FETCH) begin
      if (bus.imem_ack) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_LAST) begin
        r_cnt     <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign timeout_err = r_timeout;
  wire w_timeout_hit = (r_state == S_FETCH) && !bus.imem_ack && (r_cnt == LP_CNT_LAST);
`else
  assign timeout_err = 1'b0;
  wire w_timeout_hit = 1'b0;
`endif

  // Main fetch state machine, PC, instruction latch and misalign flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_instr    <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_instr <= bus.imem_rdata;
            r_state <= S_HOLD;
          end else if (w_timeout_hit) begin
            r_state <= S_ERR;
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            if (PCin[1:0] == 2'b00) begin
              r_pc    <= PCin;
              r_state <= S_FETCH;
            end else begin
              r_misalign <= 1'b1;
              r_state    <= S_ERR;
            end
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  // Outputs decode from registered state and PC only.
  assign bus.imem_req  = (r_state == S_FETCH);
  assign bus.imem_addr = r_pc;
  assign instr_valid   = (r_state == S_HOLD);
  assign PC            = r_pc;
  assign PCnew         = r_pc + 32'd4;
  assign instr         = r_instr;
  assign misalign_err  = r_misalign;

endmodule
